// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with tick-paced row drive, debounce and one-hot key code.
// Define KEYPAD_REPEAT_EN to build in auto-repeat while a key stays held.
module keypad_scan #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 4,
    parameter int unsigned REPEAT_DLY   = 200,
    parameter int unsigned REPEAT_PER   = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [15:0] onehot,
    output logic        key_valid
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    logic [3:0]       col_meta_q, scol_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    state_t           state_q, state_d;
    logic [1:0]       cur_row_q, cur_row_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             cnt_done;
    logic [3:0]       row_q, row_d;
    logic [15:0]      onehot_q, onehot_d, key_code;
    logic             key_valid_q, key_valid_d;
    logic             samp_idle, samp_valid;
    logic [1:0]       samp_idx;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_q, rep_d, rep_dec;
`endif

    // Scan divider: tick marks the last cycle of each row dwell.
    always_comb begin
        tick  = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Classify the synchronized column sample.
    always_comb begin
        samp_idle  = (scol_q == 4'b1111);
        samp_valid = 1'b0;
        samp_idx   = 2'd0;
        case (scol_q)
            4'b1110: begin samp_valid = 1'b1; samp_idx = 2'd0; end
            4'b1101: begin samp_valid = 1'b1; samp_idx = 2'd1; end
            4'b1011: begin samp_valid = 1'b1; samp_idx = 2'd2; end
            4'b0111: begin samp_valid = 1'b1; samp_idx = 2'd3; end
            default: ;
        endcase
    end

    always_comb begin
        cnt_inc  = (cnt_q >= CNT_W'(DEBOUNCE_CNT)) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_done = (cnt_inc >= CNT_W'(DEBOUNCE_CNT));
        key_code = 16'h0001 << {cur_row_q, col_idx_q};
    end

    always_comb begin
        state_d     = state_q;
        cur_row_d   = cur_row_q;
        col_idx_d   = col_idx_q;
        cnt_d       = cnt_q;
        onehot_d    = onehot_q;
        key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_dec     = rep_q - REP_W'(1);
        rep_d       = rep_q;
`endif
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (samp_valid) begin
                        col_idx_d = samp_idx;
                        cnt_d     = CNT_W'(1);
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        cur_row_d = cur_row_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (samp_valid && (samp_idx == col_idx_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_done) begin
                            state_d     = ST_PRESSED;
                            cnt_d       = '0;
                            onehot_d    = key_code;
                            key_valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                            rep_d       = REP_W'(REPEAT_DLY);
`endif
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        cnt_d     = '0;
                        cur_row_d = cur_row_q + 2'd1;
                    end
                end
                ST_PRESSED: begin
                    if (samp_idle) begin
                        state_d = ST_RELEASE;
                        cnt_d   = CNT_W'(1);
                    end
`ifdef KEYPAD_REPEAT_EN
                    // One tick of blank code before each repeated press.
                    else begin
                        rep_d = rep_dec;
                        if (rep_dec == REP_W'(1)) begin
                            onehot_d = '0;
                        end else if (rep_dec == '0) begin
                            onehot_d    = key_code;
                            key_valid_d = 1'b1;
                            rep_d       = REP_W'(REPEAT_PER);
                        end
                    end
`endif
                end
                ST_RELEASE: begin
                    if (samp_idle) begin
                        cnt_d = cnt_inc;
                        if (cnt_done) begin
                            state_d   = ST_SCAN;
                            cnt_d     = '0;
                            onehot_d  = '0;
                            cur_row_d = cur_row_q + 2'd1;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
        row_d = ~(4'b0001 << cur_row_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q  <= '0;
            scol_q      <= '0;
            div_q       <= '0;
            state_q     <= ST_SCAN;
            cur_row_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            cnt_q       <= '0;
            row_q       <= 4'b1110;
            onehot_q    <= '0;
            key_valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            col_meta_q  <= col;
            scol_q      <= col_meta_q;
            div_q       <= div_d;
            state_q     <= state_d;
            cur_row_q   <= cur_row_d;
            col_idx_q   <= col_idx_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            onehot_q    <= onehot_d;
            key_valid_q <= key_valid_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign row       = row_q;
    assign onehot    = onehot_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a simulated keypad answers the row drive, a tick-level reference model
// predicts onehot/key_valid events into a scoreboard that a monitor drains.
`timescale 1ns/1ps
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DBC      = 3;
    localparam int RDLY     = 8;
    localparam int RPER     = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [15:0] onehot;
    logic        key_valid;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_CNT(DBC),
        .REPEAT_DLY  (RDLY),
        .REPEAT_PER  (RPER)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .col      (col),
        .row      (row),
        .onehot   (onehot),
        .key_valid(key_valid)
    );

    // Keypad: mode 0 nothing pressed, 1 single key (kp_r,kp_c), 2 fixed column pattern on every row.
    int         kp_mode = 0;
    int         kp_r    = 0;
    int         kp_c    = 0;
    logic [3:0] kp_pat  = 4'hF;

    function automatic logic [3:0] keypad(input logic [3:0] drv, input int mode, input int r,
                                          input int c, input logic [3:0] pat);
        logic [3:0] v;
        v = 4'hF;
        if (mode == 1) begin
            if (drv[2'(r)] == 1'b0) v = ~(4'b0001 << c);
        end else if (mode == 2) begin
            v = pat;
        end
        return v;
    endfunction

    assign col = keypad(row, kp_mode, kp_r, kp_c, kp_pat);

    typedef struct packed {
        logic [15:0] oh;
        logic        kv;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] row_of(input int r);
        logic [3:0] v;
        v = 4'b0001 << r;
        return ~v;
    endfunction

    // Monitor: every visible change of onehot, or a key_valid pulse, consumes one prediction.
    logic [15:0] prev_oh = '0;
    always @(negedge clk) begin
        exp_t e;
        if ((onehot !== prev_oh) || (key_valid === 1'b1)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: onehot=%h key_valid=%b required no event at %0t",
                         onehot, key_valid, $time);
            end else begin
                e = exp_q.pop_front();
                check("event_onehot", 32'(onehot), 32'(e.oh));
                check("event_key_valid", 32'(key_valid), 32'(e.kv));
            end
        end
        check("onehot_at_most_one_bit", 32'($countones(onehot) <= 1), 32'd1);
        prev_oh = onehot;
    end

    // Reference model: tracks which row is being driven and how long a sample has persisted.
    int          m_row, m_streak, m_rel, m_ticks;
    logic [3:0]  m_cand;
    logic        m_held, m_shown;
    logic [15:0] m_code;

    task automatic model_reset();
        m_row = 0; m_streak = 0; m_rel = 0; m_ticks = 0;
        m_cand = 4'hF; m_held = 1'b0; m_shown = 1'b0; m_code = '0;
    endtask

    task automatic push(input logic [15:0] oh, input logic kv);
        exp_t e;
        e.oh = oh;
        e.kv = kv;
        exp_q.push_back(e);
    endtask

    function automatic logic [15:0] code_of(input int r, input logic [3:0] s);
        logic [15:0] v;
        int          c;
        c = 0;
        for (int i = 0; i < 4; i++) if (s[2'(i)] == 1'b0) c = i;
        v = 16'h0001 << (4 * r + c);
        return v;
    endfunction

    task automatic model_tick();
        logic [3:0] s;
        int         zeros;
        s = keypad(row_of(m_row), kp_mode, kp_r, kp_c, kp_pat);
        zeros = 4 - $countones(s);
        if (!m_held) begin
            if (m_streak == 0) begin
                if (zeros == 1) begin
                    m_streak = 1;
                    m_cand   = s;
                end else begin
                    m_row = (m_row + 1) % 4;
                end
            end else if (s == m_cand) begin
                m_streak++;
            end else begin
                m_streak = 0;
                m_row    = (m_row + 1) % 4;
            end
            if (m_streak >= DBC) begin
                m_held = 1'b1; m_shown = 1'b1;
                m_streak = 0; m_rel = 0; m_ticks = 0;
                m_code = code_of(m_row, m_cand);
                push(m_code, 1'b1);
            end
        end else if (s == 4'hF) begin
            m_rel++;
            if (m_rel >= DBC) begin
                m_held = 1'b0;
                m_rel  = 0;
                m_row  = (m_row + 1) % 4;
                if (m_shown) push(16'h0000, 1'b0);
                m_shown = 1'b0;
            end
        end else begin
`ifdef KEYPAD_REPEAT_EN
            if (m_rel == 0) begin
                m_ticks++;
                if (m_ticks >= RDLY && (m_ticks - RDLY) % RPER == 0) begin
                    push(m_code, 1'b1);
                    m_shown = 1'b1;
                end else if (m_ticks + 1 >= RDLY && (m_ticks + 1 - RDLY) % RPER == 0) begin
                    push(16'h0000, 1'b0);
                    m_shown = 1'b0;
                end
            end
`endif
            m_rel = 0;
        end
    endtask

    // One row dwell: check the row just before and just after the tick edge.
    task automatic do_tick();
        repeat (SCAN_DIV - 1) @(posedge clk);
        #1 check("row_during_dwell", 32'(row), 32'(row_of(m_row)));
        @(posedge clk);
        model_tick();
        #1 check("row_after_tick", 32'(row), 32'(row_of(m_row)));
    endtask

    task automatic set_key(input int r, input int c);
        kp_mode = 1; kp_r = r; kp_c = c;
    endtask

    task automatic set_none();
        kp_mode = 0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_onehot", 32'(onehot), 32'h0);
        check("reset_row", 32'(row), 32'hE);
        check("reset_key_valid", 32'(key_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (3) do_tick();

        // Clean press of row1/col2.
        set_key(1, 2);
        repeat (10) do_tick();
        check("clean_press_code", 32'(onehot), 32'h0040);
        set_none();
        repeat (5) do_tick();
        check("clean_release", 32'(onehot), 32'h0);

        // Bouncing row0/col0 never survives debounce.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) set_key(0, 0);
            else            set_none();
            do_tick();
        end
        check("bounce_no_key", 32'(onehot), 32'h0);

        // Two columns low on every row is a ghost pattern.
        kp_mode = 2;
        kp_pat  = 4'b1100;
        repeat (8) do_tick();
        check("ghost_no_key", 32'(onehot), 32'h0);

        // Release glitch on an accepted row1/col2.
        set_key(1, 2);
        repeat (7) do_tick();
        check("glitch_pressed", 32'(onehot), 32'h0040);
        set_none();
        repeat (2) do_tick();
        check("glitch_two_high", 32'(onehot), 32'h0040);
        set_key(1, 2);
        do_tick();
        check("glitch_low_tick", 32'(onehot), 32'h0040);
        set_none();
        repeat (2) do_tick();
        check("glitch_two_more_high", 32'(onehot), 32'h0040);
        do_tick();
        check("glitch_third_high", 32'(onehot), 32'h0);

        // Randomized keypad activity.
        for (int t = 0; t < 240; t++) begin
            int pick;
            pick = int'($urandom_range(0, 23));
            if (pick == 0) begin
                set_none();
            end else if (pick == 1) begin
                set_key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else if (pick == 2) begin
                kp_mode = 2;
                kp_pat  = 4'($urandom);
            end
            do_tick();
        end

        // Reset while row3/col3 is held.
        set_none();
        repeat (6) do_tick();
        set_key(3, 3);
        repeat (8) do_tick();
        check("hold_r3c3_code", 32'(onehot), 32'h8000);
        #2;
        push(16'h0000, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midhold_reset_onehot", 32'(onehot), 32'h0);
        check("midhold_reset_row", 32'(row), 32'hE);
        check("midhold_reset_key_valid", 32'(key_valid), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Long hold of row3/col3 (auto-repeat only in the repeat build).
        repeat (26) do_tick();
        set_none();
        repeat (6) do_tick();
        check("final_onehot", 32'(onehot), 32'h0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
